sw_debounce: RTL and testbench

- Debounces the four active-low board pushbuttons (sw1..sw4) and presents clean, registered press state to downstream logic.
- Sits directly upstream of the LED/accumulator logic in top, replacing raw `!swN` usage.
- Also emits one-cycle press/release pulses, for use as clean clock-enables or event strobes.
- Sized for the CPLD: one shared prescaler feeds small per-channel stability counters.

---
 rtl/sw_pkg.sv | 16 +
 rtl/sw_debounce_chan.sv | 64 ++++++
 rtl/sw_debounce.sv | 54 +++++
 tb/tb_sw_debounce.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/sw_pkg.sv
// Shared constants and helpers for the pushbutton debouncer.
package sw_pkg;

  localparam int unsigned SwNDefault           = 4;
  localparam int unsigned SwPreDivDefault      = 1024;
  localparam int unsigned SwStableTicksDefault = 4;

  // Ceiling log2, never less than 1 so derived widths stay legal.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/sw_debounce_chan.sv
// One debounce channel: 2-flop synchronizer, stability counter, level and edge pulses.
module sw_debounce_chan
  import sw_pkg::*;
#(
  parameter int unsigned STABLE_TICKS = SwStableTicksDefault,
  parameter int unsigned CNT_W        = clog2(STABLE_TICKS + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_n,
  input  logic tick,
  output logic level,
  output logic press,
  output logic release_p
);

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(STABLE_TICKS - 1);

  logic             sync1;
  logic             sync2;
  logic             s;
  logic [CNT_W-1:0] cnt;

  // Synchronized, active-high view of the button.
  assign s = ~sync2;

  // Two-stage synchronizer, reset to the released level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= sw_n;
      sync2 <= sync1;
    end
  end

  // Stability counter, accepted level and one-cycle edge pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      level     <= 1'b0;
      press     <= 1'b0;
      release_p <= 1'b0;
    end else begin
      press     <= 1'b0;
      release_p <= 1'b0;
      // Agreement clears the counter even on a tick, so any bounce restarts the count.
      if (s == level) begin
        cnt <= '0;
      end else if (tick) begin
        if (cnt == CntLast) begin
          level     <= s;
          cnt       <= '0;
          press     <= s;
          release_p <= ~s;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sw_debounce.sv
// Debouncer for active-low pushbuttons: shared prescaler plus N independent channels.
module sw_debounce
  import sw_pkg::*;
#(
  parameter int unsigned N            = SwNDefault,
  parameter int unsigned PRE_DIV      = SwPreDivDefault,
  parameter int unsigned PRE_W        = clog2(PRE_DIV),
  parameter int unsigned STABLE_TICKS = SwStableTicksDefault,
  parameter int unsigned CNT_W        = clog2(STABLE_TICKS + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] sw_n,
  output logic [N-1:0] level,
  output logic [N-1:0] press,
  // "release" is a reserved word, hence the suffix.
  output logic [N-1:0] release_p
);

  localparam logic [PRE_W-1:0] PreLast = PRE_W'(PRE_DIV - 1);

  logic [PRE_W-1:0] pre;
  logic             tick;

  // With PRE_DIV == 1 the counter sits at 0 and tick is permanently high.
  assign tick = (pre == PreLast);

  // Free-running prescaler, wraps after PRE_DIV cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre <= '0;
    end else if (tick) begin
      pre <= '0;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_chan
    sw_debounce_chan #(
      .STABLE_TICKS(STABLE_TICKS),
      .CNT_W       (CNT_W)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .sw_n     (sw_n[i]),
      .tick     (tick),
      .level    (level[i]),
      .press    (press[i]),
      .release_p(release_p[i])
    );
  end

endmodule

// File: tb/tb_sw_debounce.sv
// Directed self-checking bench for sw_debounce with PRE_DIV=4, STABLE_TICKS=3.
module tb_sw_debounce;

  logic       clk;
  logic       rst;
  logic [3:0] sw_n;
  logic [3:0] level;
  logic [3:0] press;
  logic [3:0] release_p;

  int n_chk;
  int n_fail;

  sw_debounce #(
    .N           (4),
    .PRE_DIV     (4),
    .STABLE_TICKS(3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sw_n     (sw_n),
    .level    (level),
    .press    (press),
    .release_p(release_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Edge k is the k-th rising edge after rst falls (edge 0 first); ticks land on k%4==3.
  task automatic run_to(input int from_edge, input int to_edge);
    for (int k = from_edge; k <= to_edge; k++) step();
  endtask

  logic [3:0] acc;
  logic       seen;

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    sw_n   = 4'b0000;

    // 1. Reset with all buttons pressed: outputs stay low.
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq("rst_level", {28'd0, level}, 32'h0);
      check_eq("rst_pulse", {24'd0, press, release_p}, 32'h0);
    end
    rst  = 1'b0;
    sw_n = 4'b1111;
    step();  // edge 0
    check_eq("c0_level", {28'd0, level}, 32'h0);
    check_eq("c0_pulse", {24'd0, press, release_p}, 32'h0);

    // 2. Clean press on channel 0: synchronized by edge 2, accepted on tick at edge 11.
    sw_n[0] = 1'b0;
    run_to(1, 10);
    check_eq("press_early", {28'd0, level}, 32'h0);
    step();  // edge 11
    check_eq("press_level", {28'd0, level}, 32'h1);
    check_eq("press_pulse", {28'd0, press}, 32'h1);
    step();  // edge 12
    check_eq("press_width", {28'd0, press}, 32'h0);
    check_eq("press_hold", {28'd0, level}, 32'h1);

    // 3. Clean release: synchronized by edge 14, ticks 15/19/23.
    sw_n[0] = 1'b1;
    acc = '0;
    for (int k = 13; k <= 22; k++) begin
      step();
      acc |= release_p;
    end
    check_eq("rel_early", {28'd0, acc}, 32'h0);
    check_eq("rel_early_lvl", {28'd0, level}, 32'h1);
    step();  // edge 23
    check_eq("rel_level", {28'd0, level}, 32'h0);
    check_eq("rel_pulse", {28'd0, release_p}, 32'h1);
    step();  // edge 24
    check_eq("rel_width", {28'd0, release_p}, 32'h0);

    // 4. Bounce on channel 1: 5-cycle phases never span three ticks.
    acc = '0;
    for (int ph = 0; ph < 8; ph++) begin
      sw_n[1] = ph[0];
      for (int k = 0; k < 5; k++) begin
        step();
        acc |= press | release_p | level;
      end
    end
    sw_n[1] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      acc |= press | release_p | level;
    end
    check_eq("bounce_quiet", {28'd0, acc}, 32'h0);

    // 5. Simultaneous press on all channels, then simultaneous release.
    sw_n = 4'b0000;
    seen = 1'b0;
    for (int k = 0; k < 24 && !seen; k++) begin
      step();
      if (level != 4'b0000) begin
        seen = 1'b1;
        check_eq("sim_level", {28'd0, level}, 32'hf);
        check_eq("sim_press", {28'd0, press}, 32'hf);
      end
    end
    check_eq("sim_seen", {31'd0, seen}, 32'h1);
    step();
    check_eq("sim_press_w", {28'd0, press}, 32'h0);
    check_eq("sim_hold", {28'd0, level}, 32'hf);
    sw_n = 4'b1111;
    seen = 1'b0;
    for (int k = 0; k < 24 && !seen; k++) begin
      step();
      if (level != 4'b1111) begin
        seen = 1'b1;
        check_eq("simr_level", {28'd0, level}, 32'h0);
        check_eq("simr_rel", {28'd0, release_p}, 32'hf);
      end
    end
    check_eq("simr_seen", {31'd0, seen}, 32'h1);
    step();
    check_eq("simr_rel_w", {28'd0, release_p}, 32'h0);

    // 6. Reset mid-debounce: channel 2 held pressed, cnt reaches 2 on tick at edge 7.
    rst  = 1'b1;
    sw_n = 4'b1011;
    step();
    rst = 1'b0;
    acc = '0;
    run_to(0, 8);
    acc |= press;
    rst = 1'b1;
    step();  // edge 9, reset while cnt[2] == 2
    check_eq("mid_rst_lvl", {28'd0, level}, 32'h0);
    check_eq("mid_rst_pulse", {24'd0, press, release_p}, 32'h0);
    rst = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      step();
      acc |= press | level;
    end
    check_eq("mid_no_early", {28'd0, acc}, 32'h0);
    step();  // edge 11 after second reset
    check_eq("mid_press", {28'd0, press}, 32'h4);
    check_eq("mid_level", {28'd0, level}, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
